bp_be_issue_queue: RTL and testbench
====================================

# bp_be_issue_queue

Parametrised checkpointing instruction queue between the FE queue input and the BE checker issue logic. It generalises the single-entry clear/dequeue/roll behaviour into a configurable-depth circular buffer with three pointers: write, speculative read and committed. Commits of up to `deq_width_p` entries per cycle are supported, and occupancy and credit status are exported. Entries read by the issue stage stay resident until committed, so a pipeline flush can roll back and replay them without refetching.

## Interface
- `els_p`, 16, queue depth; power of two, ≥ 2.
- `width_p`, 128, entry width in bits (`fe_queue_width_lp` at instantiation).
- `deq_width_p`, 2, maximum entries committed per cycle; 1 ≤ `deq_width_p` ≤ `els_p`.
- `clk_i` in 1: clock, rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `enq_data_i` in `width_p`: entry to write.
- `enq_v_i` in 1: write request; ready/valid handshake with `enq_ready_o`.
- `enq_ready_o` out 1: space available.
- `data_o` out `width_p`: entry at the speculative read pointer.
- `v_o` out 1: `data_o` valid.
- `yumi_i` in 1: issue consumes `data_o`; legal only when `v_o`.
- `deq_cnt_i` in `$clog2(deq_width_p+1)`: number of oldest read entries to commit.
- `roll_i` in 1: rewind the read pointer to the committed pointer.
- `clr_i` in 1: discard all uncommitted entries.
- `empty_o` out 1: no entries held (`wptr == cptr`).
- `count_o` out `$clog2(els_p+1)`: entries held (`wptr - cptr`).

## Operation
- Pointers `wptr`, `rptr`, `cptr`: each `$clog2(els_p)+1` bits, wrap bit at the MSB. Index is the low bits. Arithmetic is modulo 2^(ptr width).
- Invariant: `cptr ≤ rptr ≤ wptr` in circular order.
- `count = wptr - cptr`.
- `enq_ready_o = (count != els_p)`; full means equal indices with differing wrap bits.
- `v_o = (rptr != wptr)`.
- `data_o = mem[rptr index]`, combinational read.
- Next-state evaluation, in order:
  - `cptr_n = cptr + deq_cnt_i`. Commit always applies, including in a cycle with clear or roll.
  - If `clr_i`: `wptr_n = rptr_n = cptr_n`; the enqueue is dropped even if `enq_v_i & enq_ready_o`.
  - Else if `roll_i`: `rptr_n = cptr_n`; `yumi_i` is ignored; enqueue proceeds normally.
  - Else: `rptr_n = rptr + yumi_i`; `wptr_n = wptr + (enq_v_i & enq_ready_o)`.
- Memory write happens on a successful enqueue (not dropped by `clr_i`) at the `wptr` index.
- Legality, checked by assertions and not corrected in hardware:
  - `deq_cnt_i ≤ rptr - cptr`, evaluated before this cycle's yumi.
  - `yumi_i` only when `v_o`.
  - `enq_v_i` is not required to wait for `enq_ready_o`.
- Simultaneous `roll_i` and `clr_i`: clear wins.
- Enqueue while full: not accepted; `enq_ready_o` is low.
- Commit freeing space in the same cycle as full: `enq_ready_o` does not see the freed space until the next cycle. There is no same-cycle bypass.

## Timing
- Reset (asynchronous assert, synchronous release with `clk_i`):
  - All pointers are 0.
  - `v_o=0`, `enq_ready_o=1`, `empty_o=1`, `count_o=0`.
  - `data_o` is X; memory is not reset.
- Enqueue to `v_o`: 1 cycle. An entry written at edge N is visible after edge N.
- No write-to-read bypass. With `v_o=0`, an enqueue in cycle N gives `v_o=1` in cycle N+1.
- `yumi_i` at edge N: `data_o` shows the next entry after edge N.
- Roll or clear at edge N: `v_o` and `data_o` reflect the rewound pointer in cycle N+1.
- Commit at edge N: `count_o` and `enq_ready_o` update in cycle N+1.
- Reset asserted mid-operation: all state is discarded immediately (asynchronous); the same values as at power-on reset are applied.

## Structure
- Storage: `bsg_mem_1r1w` with `els_p` × `width_p`, asynchronous read, write enable from the enqueue logic.
- A single sub-module, `bp_be_issue_queue_ptr`, holds the circular pointers: wrap-bit pointer register with async active-low reset, add-by-N, load. It is instantiated three times, with `N=1` for write and read and `N=deq_width_p` for commit.
- Shared package `bp_be_pkg` gets the macro `bp_be_issue_queue_ptr_width(els)` (`$clog2(els)+1`) so the checker can size its credit counters.
- No new structs; entries are opaque `width_p` vectors.

## Test plan
- Fill and drain, `els_p=16`:
  - Enqueue values 0..15 → `enq_ready_o=0` and `count_o=16`.
  - Yumi all, commit 2 per cycle → `data_o` returns 0..15 in order, then `empty_o=1` 8 cycles after the last yumi.
- Roll and replay:
  - Enqueue A..E, yumi A..D, commit 1 (A), roll → next `data_o`=B, `count_o=4`.
  - Yumi B..E again → same data.
- Clear with simultaneous commit and enqueue:
  - Held A..F, read A..C; in one cycle `deq_cnt_i=2`, `clr_i=1`, `enq_v_i=1` (G) → `count_o=0`, `v_o=0`, G not stored.
- Wrap-around:
  - 40 enqueue/yumi/commit iterations with depth 16 → pointer wrap bit toggles; data stays ordered and full/empty are correct at each wrap.
- Full with commit in the same cycle:
  - Full queue, commit 1 → `enq_ready_o` stays 0 that cycle and is 1 the next.
  - An enqueue then lands in the freed slot.
- Asynchronous reset mid-stream:
  - Assert `reset_n_i` low between edges with 7 entries held → `count_o=0`, `v_o=0` immediately.
  - After release, enqueue X → `data_o`=X one cycle later.

Source files
------------

// File: rtl/bp_be_issue_queue_pkg.sv
// Shared definitions for the BE issue queue: pointer sizing helpers.
// The macro lets code outside this package (e.g. checker credit counters)
// size a queue pointer without importing anything.
`ifndef BP_BE_ISSUE_QUEUE_PTR_WIDTH_DEFINED
`define BP_BE_ISSUE_QUEUE_PTR_WIDTH_DEFINED
`define BP_BE_ISSUE_QUEUE_PTR_WIDTH(els) ($clog2(els)+1)
`endif

package bp_be_issue_queue_pkg;

    // Pointer width: index bits plus one wrap bit at the MSB.
    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    // Width of a counter able to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bp_be_issue_queue_if.sv
// Handshake bundle between the FE queue / BE checker and the issue queue.
// The master side is the surrounding pipeline, the slave side is the queue.
interface bp_be_issue_queue_if #(
    parameter int els_p       = 16,
    parameter int width_p     = 128,
    parameter int deq_width_p = 2
);
    localparam int cnt_width_lp     = $clog2(els_p + 1);
    localparam int deq_cnt_width_lp = $clog2(deq_width_p + 1);

    logic [width_p-1:0]          enq_data_i;
    logic                        enq_v_i;
    logic                        enq_ready_o;
    logic [width_p-1:0]          data_o;
    logic                        v_o;
    logic                        yumi_i;
    logic [deq_cnt_width_lp-1:0] deq_cnt_i;
    logic                        roll_i;
    logic                        clr_i;
    logic                        empty_o;
    logic [cnt_width_lp-1:0]     count_o;

    modport master (
        output enq_data_i, enq_v_i, yumi_i, deq_cnt_i, roll_i, clr_i,
        input  enq_ready_o, data_o, v_o, empty_o, count_o
    );

    modport slave (
        input  enq_data_i, enq_v_i, yumi_i, deq_cnt_i, roll_i, clr_i,
        output enq_ready_o, data_o, v_o, empty_o, count_o
    );
endinterface

// File: rtl/bp_be_issue_queue_ptr.sv
// Circular queue pointer with wrap bit: either loads a new value or
// advances by a small amount each cycle.
module bp_be_issue_queue_ptr #(
    parameter  int ptr_width_p  = 5,
    parameter  int max_add_p    = 1,
    localparam int add_width_lp = $clog2(max_add_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [add_width_lp-1:0] add_i,
    input  logic                    load_v_i,
    input  logic [ptr_width_p-1:0]  load_i,
    output logic [ptr_width_p-1:0]  ptr_o
);

    logic [ptr_width_p-1:0] ptr_r;

    // Pointer register: load has priority over the increment.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else if (load_v_i) begin
            ptr_r <= load_i;
        end else begin
            ptr_r <= ptr_r + ptr_width_p'(add_i);
        end
    end

    assign ptr_o = ptr_r;

endmodule

// File: rtl/bp_be_issue_queue.sv
// Checkpointing issue queue: circular buffer with write, speculative read
// and committed pointers. Read entries stay resident until committed so a
// roll can replay them.
module bp_be_issue_queue
    import bp_be_issue_queue_pkg::*;
#(
    parameter int els_p       = 16,
    parameter int width_p     = 128,
    parameter int deq_width_p = 2
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    bp_be_issue_queue_if.slave  q
);

    localparam int ptr_width_lp = ptr_width(els_p);
    localparam int idx_width_lp = ptr_width_lp - 1;
    localparam int cnt_width_lp = cnt_width(els_p);

    logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_n;
    logic [ptr_width_lp-1:0] held, rd_span;
    logic                    enq_fire, mem_we;
    logic                    w_load, w_add, r_load, r_add;

    logic [width_p-1:0]      mem [els_p];

    assign held     = wptr - cptr;
    assign rd_span  = rptr - cptr;
    assign cptr_n   = cptr + ptr_width_lp'(q.deq_cnt_i);
    assign enq_fire = q.enq_v_i & q.enq_ready_o;
    assign mem_we   = enq_fire & ~q.clr_i;

    // Pointer control: clear beats roll, roll ignores yumi; commit always applies.
    always_comb begin
        w_load = 1'b0;
        w_add  = 1'b0;
        r_load = 1'b0;
        r_add  = 1'b0;
        if (q.clr_i) begin
            w_load = 1'b1;
            r_load = 1'b1;
        end else if (q.roll_i) begin
            r_load = 1'b1;
            w_add  = enq_fire;
        end else begin
            r_add  = q.yumi_i;
            w_add  = enq_fire;
        end
    end

    bp_be_issue_queue_ptr #(
        .ptr_width_p(ptr_width_lp),
        .max_add_p  (1)
    ) wptr_u (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .add_i    (w_add),
        .load_v_i (w_load),
        .load_i   (cptr_n),
        .ptr_o    (wptr)
    );

    bp_be_issue_queue_ptr #(
        .ptr_width_p(ptr_width_lp),
        .max_add_p  (1)
    ) rptr_u (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .add_i    (r_add),
        .load_v_i (r_load),
        .load_i   (cptr_n),
        .ptr_o    (rptr)
    );

    bp_be_issue_queue_ptr #(
        .ptr_width_p(ptr_width_lp),
        .max_add_p  (deq_width_p)
    ) cptr_u (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .add_i    (q.deq_cnt_i),
        .load_v_i (1'b0),
        .load_i   ('0),
        .ptr_o    (cptr)
    );

    // Entry storage (1R1W, async read); contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wptr[idx_width_lp-1:0]] <= q.enq_data_i;
        end
    end

    assign q.data_o      = mem[rptr[idx_width_lp-1:0]];
    assign q.v_o         = (rptr != wptr);
    assign q.empty_o     = (wptr == cptr);
    assign q.enq_ready_o = (held != ptr_width_lp'(els_p));
    assign q.count_o     = cnt_width_lp'(held);

`ifndef SYNTHESIS
    // Usage rules the hardware does not correct.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!q.yumi_i || q.v_o);
            assert (ptr_width_lp'(q.deq_cnt_i) <= rd_span);
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench for bp_be_issue_queue (depth 16, 32-bit entries, commit 2).
module tb_bp_be_issue_queue;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    bp_be_issue_queue_if #(.els_p(16), .width_p(32), .deq_width_p(2)) qif ();

    bp_be_issue_queue #(.els_p(16), .width_p(32), .deq_width_p(2)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .q        (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        qif.enq_v_i    = 1'b0;
        qif.enq_data_i = '0;
        qif.yumi_i     = 1'b0;
        qif.deq_cnt_i  = '0;
        qif.roll_i     = 1'b0;
        qif.clr_i      = 1'b0;
    endtask

    // One clock with the given inputs; returns #1 after the rising edge.
    task automatic cyc(input logic ev, input logic [31:0] d, input logic y,
                       input logic [1:0] dc, input logic rl, input logic cl);
        qif.enq_v_i    = ev;
        qif.enq_data_i = d;
        qif.yumi_i     = y;
        qif.deq_cnt_i  = dc;
        qif.roll_i     = rl;
        qif.clr_i      = cl;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        idle();
        #12;
        chk("rst_count", 32'(qif.count_o), 32'd0);
        chk("rst_v", 32'(qif.v_o), 32'd0);
        chk("rst_ready", 32'(qif.enq_ready_o), 32'd1);
        chk("rst_empty", 32'(qif.empty_o), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill 0..15, then try one more while full.
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0, 2'd0, 1'b0, 1'b0);
        chk("full_ready", 32'(qif.enq_ready_o), 32'd0);
        chk("full_count", 32'(qif.count_o), 32'd16);
        chk("full_v", 32'(qif.v_o), 32'd1);
        chk("full_empty", 32'(qif.empty_o), 32'd0);
        cyc(1'b1, 32'h99, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("enq_when_full_count", 32'(qif.count_o), 32'd16);
        chk("enq_when_full_ready", 32'(qif.enq_ready_o), 32'd0);

        // Read all in order, then commit 2 per cycle.
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", qif.data_o, 32'(i));
            cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        chk("drain_v", 32'(qif.v_o), 32'd0);
        chk("drain_count_uncommitted", 32'(qif.count_o), 32'd16);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
            chk("commit_count", 32'(qif.count_o), 32'(16 - 2 * (j + 1)));
        end
        chk("drain_empty", 32'(qif.empty_o), 32'd1);
        chk("drain_ready", 32'(qif.enq_ready_o), 32'd1);

        // Roll and replay.
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'hA0 + 32'(k), 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("roll_first_read", qif.data_o, 32'hA0 + 32'(k));
            cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        cyc(1'b0, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0);
        chk("roll_pre_count", 32'(qif.count_o), 32'd4);
        cyc(1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("roll_data", qif.data_o, 32'hA1);
        chk("roll_count", 32'(qif.count_o), 32'd4);
        chk("roll_v", 32'(qif.v_o), 32'd1);
        for (int k = 1; k < 5; k++) begin
            chk("replay_data", qif.data_o, 32'hA0 + 32'(k));
            cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        chk("replay_v", 32'(qif.v_o), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        chk("replay_empty", 32'(qif.empty_o), 32'd1);

        // Clear with simultaneous commit and enqueue.
        for (int k = 0; k < 6; k++) cyc(1'b1, 32'hB0 + 32'(k), 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("clr_read", qif.data_o, 32'hB0 + 32'(k));
            cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        cyc(1'b1, 32'hC6, 1'b0, 2'd2, 1'b0, 1'b1);
        chk("clr_count", 32'(qif.count_o), 32'd0);
        chk("clr_v", 32'(qif.v_o), 32'd0);
        chk("clr_empty", 32'(qif.empty_o), 32'd1);
        cyc(1'b1, 32'hD0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("post_clr_data", qif.data_o, 32'hD0);
        chk("post_clr_count", 32'(qif.count_o), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0);
        chk("post_clr_empty", 32'(qif.empty_o), 32'd1);

        // Streaming across several pointer wraps.
        cyc(1'b1, 32'h1000, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("wrap_data", qif.data_o, 32'h1000 + 32'(i));
            chk("wrap_count", 32'(qif.count_o), (i == 0) ? 32'd1 : 32'd2);
            chk("wrap_ready", 32'(qif.enq_ready_o), 32'd1);
            cyc(1'b1, 32'h1000 + 32'(i + 1), 1'b1, (i > 0) ? 2'd1 : 2'd0, 1'b0, 1'b0);
        end
        chk("wrap_end_count", 32'(qif.count_o), 32'd2);
        chk("wrap_end_data", qif.data_o, 32'h1028);
        cyc(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0);
        chk("wrap_end_empty", 32'(qif.empty_o), 32'd1);

        // Full with a commit in the same cycle: no bypass of freed space.
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'hF0 + 32'(i), 1'b0, 2'd0, 1'b0, 1'b0);
        chk("fc_full_ready", 32'(qif.enq_ready_o), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("fc_read_count", 32'(qif.count_o), 32'd16);
        qif.deq_cnt_i  = 2'd1;
        qif.enq_v_i    = 1'b1;
        qif.enq_data_i = 32'h77;
        #1;
        chk("fc_same_cycle_ready", 32'(qif.enq_ready_o), 32'd0);
        @(posedge clk);
        #1;
        idle();
        chk("fc_next_ready", 32'(qif.enq_ready_o), 32'd1);
        chk("fc_next_count", 32'(qif.count_o), 32'd15);
        cyc(1'b1, 32'h55, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("fc_refill_count", 32'(qif.count_o), 32'd16);
        chk("fc_refill_ready", 32'(qif.enq_ready_o), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk("fc_drain_data", qif.data_o, 32'hF0 + 32'(i));
            cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        chk("fc_freed_slot_data", qif.data_o, 32'h55);
        cyc(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("fc_drain_v", 32'(qif.v_o), 32'd0);
        for (int j = 0; j < 8; j++) cyc(1'b0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        chk("fc_empty", 32'(qif.empty_o), 32'd1);

        // Asynchronous reset between edges with 7 entries held.
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 2'd0, 1'b0, 1'b0);
        chk("ar_pre_count", 32'(qif.count_o), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(qif.count_o), 32'd0);
        chk("ar_v", 32'(qif.v_o), 32'd0);
        chk("ar_ready", 32'(qif.enq_ready_o), 32'd1);
        chk("ar_empty", 32'(qif.empty_o), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 32'hCAFE, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("ar_after_v", 32'(qif.v_o), 32'd1);
        chk("ar_after_data", qif.data_o, 32'hCAFE);
        chk("ar_after_count", 32'(qif.count_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
